// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the Thumb-subset instruction sequencer.
// Holds the sequencer state encoding and the fetch/PC geometry.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } seq_state_t;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam int          INSTR_W          = 16;
    localparam int          PC_STEP          = 2;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and its memories.
// The sequencer side is the master; the memory side answers with acks and fetch data.
interface instr_sequencer_if
    import seq_pkg::*;
#(
    parameter int ADDR_W = 16
);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dmem_req;
    logic               dmem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        output dmem_ack
    );

endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: fetches halfwords, stretches loads/stores over the
// data handshake, injects one control-unit micro-op per fetch and retires the PC.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    instr_sequencer_if.master  mem_if,
    output logic [INSTR_W-1:0] instr_o,
    output logic               cu_input_en_o,
    input  logic [INSTR_W-1:0] self_instruct_i,
    input  logic               self_instruct_en_i,
    input  logic               mem_load_i,
    input  logic               mem_write_i,
    input  logic               branch_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               end_program_i,
    input  logic               rf_write_en_i,
    input  logic               sp_write_en_i,
    output logic               rf_we_o,
    output logic               sp_we_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic [31:0]        instr_count_o
);

    seq_state_t         state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic               inj_q;
    logic               br_q;
    logic [ADDR_W-1:0]  tgt_q;
    logic [31:0]        cnt_q;

    logic               mem_op;
    logic               complete;
    logic               inject;
    logic               retire;
    logic               br_take;
    logic [ADDR_W-1:0]  br_dest;
    logic [ADDR_W-1:0]  pc_d;

    assign mem_op   = mem_load_i | mem_write_i;
    assign complete = ((state_q == S_EXEC) && !end_program_i && !mem_op) ||
                      ((state_q == S_MEM) && mem_if.dmem_ack);
    // Only the fetched op may inject, so an injected op's request is dropped here.
    assign inject   = complete && self_instruct_en_i && !inj_q;
    assign retire   = complete && !inject;

    // After an injection the branch decision comes from the fetched op, held in br_q/tgt_q.
    assign br_take  = inj_q ? br_q  : branch_i;
    assign br_dest  = inj_q ? tgt_q : branch_target_i;
    assign pc_d     = br_take ? br_dest : pc_q + ADDR_W'(PC_STEP);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            inj_q   <= 1'b0;
            br_q    <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start_i) begin
                        pc_q    <= RESET_PC;
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_if.imem_ack) begin
                        ir_q    <= mem_if.imem_rdata;
                        inj_q   <= 1'b0;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (end_program_i) begin
                        state_q <= S_HALT;
                    end else if (mem_op) begin
                        state_q <= S_MEM;
                    end
                end
                S_MEM: ;
                default: state_q <= S_IDLE;
            endcase

            if (inject) begin
                ir_q    <= self_instruct_i;
                inj_q   <= 1'b1;
                br_q    <= branch_i;
                tgt_q   <= branch_target_i;
                state_q <= S_EXEC;
            end else if (retire) begin
                pc_q    <= pc_d;
                cnt_q   <= cnt_q + 32'd1;
                state_q <= S_FETCH;
            end
        end
    end

    assign mem_if.imem_req  = (state_q == S_FETCH);
    assign mem_if.imem_addr = pc_q;
    assign mem_if.dmem_req  = (state_q == S_MEM);

    assign instr_o       = ir_q;
    assign cu_input_en_o = (state_q == S_EXEC) || (state_q == S_MEM);
    assign rf_we_o       = complete && rf_write_en_i;
    assign sp_we_o       = complete && sp_write_en_i;
    assign pc_o          = pc_q;
    assign busy_o        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
    assign halted_o      = (state_q == S_HALT);
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: emulated control unit and memories, a directed program table,
// a random program against an instruction-level model, and reset-in-handshake sequences.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni, start_i;
    logic [15:0]   instr_o, self_instruct_i;
    logic          cu_input_en_o, self_instruct_en_i, mem_load_i, mem_write_i;
    logic          branch_i, end_program_i, rf_write_en_i, sp_write_en_i;
    logic          rf_we_o, sp_we_o, busy_o, halted_o;
    logic [AW-1:0] branch_target_i, pc_o;
    logic [31:0]   instr_count_o;

    instr_sequencer_if #(.ADDR_W(AW)) mem_if ();

    instr_sequencer #(.ADDR_W(AW), .RESET_PC(16'h0000)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .start_i            (start_i),
        .mem_if             (mem_if),
        .instr_o            (instr_o),
        .cu_input_en_o      (cu_input_en_o),
        .self_instruct_i    (self_instruct_i),
        .self_instruct_en_i (self_instruct_en_i),
        .mem_load_i         (mem_load_i),
        .mem_write_i        (mem_write_i),
        .branch_i           (branch_i),
        .branch_target_i    (branch_target_i),
        .end_program_i      (end_program_i),
        .rf_write_en_i      (rf_write_en_i),
        .sp_write_en_i      (sp_write_en_i),
        .rf_we_o            (rf_we_o),
        .sp_we_o            (sp_we_o),
        .pc_o               (pc_o),
        .busy_o             (busy_o),
        .halted_o           (halted_o),
        .instr_count_o      (instr_count_o)
    );

    // Control-unit emulation: decodes instr_o combinationally, like the real decoder.
    typedef struct packed {
        logic        ld, wr, rf, sp, self_en, br, end_p;
        logic [15:0] self_w;
        logic [15:0] tgt;
    } cu_t;

    function automatic cu_t decode(input logic [15:0] w, input logic rnd);
        cu_t c;
        c = '0;
        if (rnd) begin
            c.ld      = w[15] & w[0];
            c.wr      = w[15] & ~w[0];
            c.rf      = w[14];
            c.sp      = w[13];
            c.self_en = w[12];
            c.br      = w[11];
            c.tgt     = {4'h0, w[10:0], 1'b0};
            c.self_w  = {w[10:8], 1'b1, w[7], 11'h155};
            c.end_p   = (w == 16'h0000);
        end else begin
            case (w)
                16'h2005: c.rf = 1'b1;
                16'h5800: begin c.ld = 1'b1; c.rf = 1'b1; end
                16'hB500: begin c.wr = 1'b1; c.sp = 1'b1; c.self_en = 1'b1; c.self_w = 16'h9701; end
                16'h9701: c.wr = 1'b1;
                16'hE7FE: begin c.br = 1'b1; c.tgt = 16'hFFFE; end
                16'hE010: begin c.br = 1'b1; c.tgt = 16'h0040; end
                16'h6001: c.wr = 1'b1;
                16'h0000: c.end_p = 1'b1;
                default: ;
            endcase
        end
        return c;
    endfunction

    logic rnd_mode, rf_force, dack_force;
    cu_t  cu;
    assign cu                 = decode(instr_o, rnd_mode);
    assign mem_load_i         = cu.ld;
    assign mem_write_i        = cu.wr;
    assign rf_write_en_i      = cu.rf | rf_force;
    assign sp_write_en_i      = cu.sp;
    assign self_instruct_en_i = cu.self_en;
    assign self_instruct_i    = cu.self_w;
    assign branch_i           = cu.br;
    assign branch_target_i    = cu.tgt;
    assign end_program_i      = cu.end_p;

    logic        iack_r, dack_r;
    logic [15:0] irdata_r;
    assign mem_if.imem_ack   = iack_r;
    assign mem_if.imem_rdata = irdata_r;
    assign mem_if.dmem_ack   = dack_r | dack_force;

    typedef struct {
        logic [15:0] w;
        int          iw;
        int          dw;
    } ent_t;

    typedef struct {
        int          cu;
        int          rf;
        int          sp;
        logic [15:0] pc;
        logic [15:0] addr;
        logic [31:0] cnt;
        logic [15:0] last;
    } obs_t;

    typedef struct {
        logic [15:0] w;
        int          iw;
        int          dw;
        int          cu;
        int          rf;
        int          sp;
        logic [15:0] pc;
        logic [31:0] cnt;
        logic [15:0] last;
    } vec_t;

    ent_t prog_q[$];
    obs_t obs_q[$];
    obs_t exp_q[$];

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input int i, input obs_t o, input obs_t e);
        chk($sformatf("%s[%0d].cu_cycles", tag, i), 32'(o.cu), 32'(e.cu));
        chk($sformatf("%s[%0d].rf_pulses", tag, i), 32'(o.rf), 32'(e.rf));
        chk($sformatf("%s[%0d].sp_pulses", tag, i), 32'(o.sp), 32'(e.sp));
        chk($sformatf("%s[%0d].pc", tag, i), 32'(o.pc), 32'(e.pc));
        chk($sformatf("%s[%0d].imem_addr", tag, i), 32'(o.addr), 32'(e.pc));
        chk($sformatf("%s[%0d].count", tag, i), o.cnt, e.cnt);
        chk($sformatf("%s[%0d].last_ir", tag, i), 32'(o.last), 32'(e.last));
    endtask

    // Memory responders drive at negedge; the monitor samples 1 time unit later so that
    // combinational write enables reflect this cycle's acks.
    initial begin : resp_mon
        int   icnt, dcnt, cur_dw, need;
        logic req_prev, halt_prev;
        obs_t acc;
        iack_r = 1'b0; dack_r = 1'b0; irdata_r = '0;
        icnt = 0; dcnt = 0; cur_dw = 0; req_prev = 1'b0; halt_prev = 1'b0;
        acc = '{0, 0, 0, '0, '0, '0, '0};
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                iack_r = 1'b0; dack_r = 1'b0; icnt = 0; dcnt = 0;
                req_prev = 1'b0; halt_prev = 1'b0;
                acc = '{0, 0, 0, '0, '0, '0, '0};
                continue;
            end
            if (iack_r) begin
                iack_r = 1'b0;
                icnt   = 0;
            end else if (mem_if.imem_req) begin
                need = (prog_q.size() > 0) ? prog_q[0].iw : 0;
                if (icnt >= need) begin
                    iack_r = 1'b1;
                    if (prog_q.size() > 0) begin
                        irdata_r = prog_q[0].w;
                        cur_dw   = prog_q[0].dw;
                        void'(prog_q.pop_front());
                    end else begin
                        irdata_r = 16'h0000;
                        cur_dw   = 0;
                    end
                end else begin
                    icnt++;
                end
            end
            if (dack_r) begin
                dack_r = 1'b0;
                dcnt   = 0;
            end else if (mem_if.dmem_req) begin
                if (dcnt >= cur_dw) dack_r = 1'b1;
                else dcnt++;
            end
            #1;
            chk("no_we_during_fetch", 32'((rf_we_o | sp_we_o) & mem_if.imem_req), 32'd0);
            if ((mem_if.imem_req && !req_prev) || (halted_o && !halt_prev)) begin
                acc.pc   = pc_o;
                acc.addr = mem_if.imem_addr;
                acc.cnt  = instr_count_o;
                obs_q.push_back(acc);
                acc = '{0, 0, 0, '0, '0, '0, '0};
            end
            if (cu_input_en_o) begin
                acc.cu++;
                acc.last = instr_o;
            end
            acc.rf += int'(rf_we_o);
            acc.sp += int'(sp_we_o);
            req_prev  = mem_if.imem_req;
            halt_prev = halted_o;
        end
    end

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_halt(input int lim, input bit poke);
        int n;
        n = 0;
        while (!halted_o && n < lim) begin
            @(negedge clk);
            start_i = (poke && busy_o && (n % 23 == 5)) ? 1'b1 : 1'b0;
            n++;
        end
        start_i = 1'b0;
        chk("halt_reached", 32'(halted_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    vec_t dir[8];

    initial begin : main
        obs_t e;
        logic [15:0] w, s, mpc;
        logic [31:0] mcnt;
        int iw, dw, n;

        rst_ni = 1'b0; start_i = 1'b0; rnd_mode = 1'b0; rf_force = 1'b0; dack_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.imem_req", 32'(mem_if.imem_req), 32'd0);
        chk("rst.dmem_req", 32'(mem_if.dmem_req), 32'd0);
        chk("rst.cu_en", 32'(cu_input_en_o), 32'd0);
        chk("rst.rf_we", 32'(rf_we_o), 32'd0);
        chk("rst.sp_we", 32'(sp_we_o), 32'd0);
        chk("rst.pc", 32'(pc_o), 32'h0000);
        chk("rst.instr", 32'(instr_o), 32'h0000);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.halted", 32'(halted_o), 32'd0);
        chk("rst.count", instr_count_o, 32'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle.busy", 32'(busy_o), 32'd0);

        // word, fetch wait, data wait, CU-enabled cycles, rf pulses, sp pulses, pc, count, last IR
        dir[0] = '{16'h2005, 0, 0, 1, 1, 0, 16'h0002, 32'd1, 16'h2005};
        dir[1] = '{16'h5800, 1, 2, 4, 1, 0, 16'h0004, 32'd2, 16'h5800};
        dir[2] = '{16'hB500, 0, 1, 6, 0, 1, 16'h0006, 32'd3, 16'h9701};
        dir[3] = '{16'hE7FE, 2, 0, 1, 0, 0, 16'hFFFE, 32'd4, 16'hE7FE};
        dir[4] = '{16'h2005, 0, 0, 1, 1, 0, 16'h0000, 32'd5, 16'h2005};
        dir[5] = '{16'hE010, 1, 0, 1, 0, 0, 16'h0040, 32'd6, 16'hE010};
        dir[6] = '{16'h6001, 0, 0, 2, 0, 0, 16'h0042, 32'd7, 16'h6001};
        dir[7] = '{16'h0000, 0, 0, 1, 0, 0, 16'h0042, 32'd7, 16'h0000};
        foreach (dir[i]) prog_q.push_back('{dir[i].w, dir[i].iw, dir[i].dw});
        pulse_start();
        wait_halt(400, 1'b0);
        chk("dir.records", 32'(obs_q.size()), 32'd9);
        if (obs_q.size() == 9) begin
            chk("dir.first_fetch_addr", 32'(obs_q[0].addr), 32'h0000);
            chk("dir.first_fetch_count", obs_q[0].cnt, 32'd0);
            for (int i = 0; i < 8; i++) begin
                e = '{dir[i].cu, dir[i].rf, dir[i].sp, dir[i].pc, dir[i].pc, dir[i].cnt, dir[i].last};
                cmp("dir", i, obs_q[i + 1], e);
            end
        end
        chk("halt.halted", 32'(halted_o), 32'd1);
        chk("halt.busy", 32'(busy_o), 32'd0);
        chk("halt.imem_req", 32'(mem_if.imem_req), 32'd0);
        chk("halt.dmem_req", 32'(mem_if.dmem_req), 32'd0);
        chk("halt.cu_en", 32'(cu_input_en_o), 32'd0);

        // Random program, checked instruction by instruction against a timing/PC model.
        obs_q.delete();
        prog_q.delete();
        rnd_mode = 1'b1;
        mpc  = 16'h0000;
        mcnt = 32'd0;
        for (int k = 0; k < 120; k++) begin
            w  = 16'($urandom);
            if (w == 16'h0000) w = 16'h4000;
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            s  = {w[10:8], 1'b1, w[7], 11'h155};
            e.cu = 1 + (w[15] ? dw + 1 : 0) + (w[12] ? 1 + (s[15] ? dw + 1 : 0) : 0);
            e.rf = int'(w[14]) + (w[12] ? int'(s[14]) : 0);
            e.sp = int'(w[13]) + (w[12] ? int'(s[13]) : 0);
            mpc  = w[11] ? {4'h0, w[10:0], 1'b0} : mpc + 16'd2;
            mcnt = mcnt + 32'd1;
            e.pc = mpc; e.addr = mpc; e.cnt = mcnt;
            e.last = w[12] ? s : w;
            prog_q.push_back('{w, iw, dw});
            exp_q.push_back(e);
        end
        prog_q.push_back('{16'h0000, 1, 0});
        exp_q.push_back('{1, 0, 0, mpc, mpc, mcnt, 16'h0000});
        pulse_start();
        wait_halt(8000, 1'b1);
        chk("rnd.records", 32'(obs_q.size()), 32'(exp_q.size() + 1));
        if (obs_q.size() == exp_q.size() + 1) begin
            chk("rnd.restart_addr", 32'(obs_q[0].addr), 32'h0000);
            chk("rnd.restart_count", obs_q[0].cnt, 32'd0);
            foreach (exp_q[i]) cmp("rnd", i, obs_q[i + 1], exp_q[i]);
        end

        // Reset while a load waits on the data handshake, then a late ack.
        rnd_mode = 1'b0;
        prog_q.delete();
        prog_q.push_back('{16'h5800, 0, 40});
        pulse_start();
        n = 0;
        while (!mem_if.dmem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstmem.reached_mem", 32'(mem_if.dmem_req), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("rstmem.dmem_req", 32'(mem_if.dmem_req), 32'd0);
        chk("rstmem.busy", 32'(busy_o), 32'd0);
        chk("rstmem.cu_en", 32'(cu_input_en_o), 32'd0);
        chk("rstmem.pc", 32'(pc_o), 32'h0000);
        chk("rstmem.instr", 32'(instr_o), 32'h0000);
        rst_ni = 1'b1;
        dack_force = 1'b1;
        rf_force = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("late_ack[%0d].rf_we", c), 32'(rf_we_o), 32'd0);
            chk($sformatf("late_ack[%0d].sp_we", c), 32'(sp_we_o), 32'd0);
            chk($sformatf("late_ack[%0d].busy", c), 32'(busy_o), 32'd0);
        end
        dack_force = 1'b0;
        rf_force = 1'b0;
        chk("late_ack.count", instr_count_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
